// File: rtl/ex_stage_if.sv
// ID/EX-side bundle for the execute stage: decoded operands and controls in,
// EX/MEM pipeline register contents and the upstream stall request out.
interface ex_stage_if;
  logic [31:0] inst_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic [31:0] store_data_i;
  logic [1:0]  EX_signal_i;
  logic [2:0]  MEM_signal_i;
  logic [1:0]  WB_signal_i;
  logic        flush_i;

  logic        stall_o;
  logic [31:0] inst_o;
  logic [31:0] ALUresult_o;
  logic [31:0] store_data_o;
  logic        zero_o;
  logic [2:0]  MEM_signal_o;
  logic [1:0]  WB_signal_o;

  modport master (
    output inst_i, RSdata_i, RTdata_i, store_data_i,
    output EX_signal_i, MEM_signal_i, WB_signal_i, flush_i,
    input  stall_o, inst_o, ALUresult_o, store_data_o,
    input  zero_o, MEM_signal_o, WB_signal_o
  );

  modport slave (
    input  inst_i, RSdata_i, RTdata_i, store_data_i,
    input  EX_signal_i, MEM_signal_i, WB_signal_i, flush_i,
    output stall_o, inst_o, ALUresult_o, store_data_o,
    output zero_o, MEM_signal_o, WB_signal_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step shift-add multiplier that
// stalls upstream while it iterates. Results land in the EX/MEM register.
module ex_stage (
  input  logic     clk_i,
  input  logic     rst_n_i,
  ex_stage_if.slave bus
);

  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_MUL, OP_NONE} op_e;
  typedef enum logic {IDLE, MUL_BUSY} state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  op_e         op;
  logic [31:0] alu_result;
  logic [31:0] ex_result;
  logic        is_mul;
  logic        stall;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q, mplier_q, acc_q;
  logic [31:0] acc_step;

  // Operation decode
  always_comb begin
    // NOTE: default first, so no path through the case leaves op unassigned (no latch).
    op = OP_NONE;
    case (bus.EX_signal_i)
      2'b00, 2'b11: op = OP_ADD;
      2'b01:        op = OP_SUB;
      default: begin
        case (bus.inst_i[14:12])
          3'b000: begin
            if (bus.inst_i[31:25] == 7'b0000000)      op = OP_ADD;
            else if (bus.inst_i[31:25] == 7'b0100000) op = OP_SUB;
            else if (bus.inst_i[31:25] == 7'b0000001) op = OP_MUL;
          end
          3'b111:  op = OP_AND;
          3'b110:  op = OP_OR;
          3'b001:  op = OP_SLL;
          default: op = OP_NONE;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = bus.RSdata_i + bus.RTdata_i;
      OP_SUB:  alu_result = bus.RSdata_i - bus.RTdata_i;
      OP_AND:  alu_result = bus.RSdata_i & bus.RTdata_i;
      OP_OR:   alu_result = bus.RSdata_i | bus.RTdata_i;
      OP_SLL:  alu_result = bus.RSdata_i << bus.RTdata_i[4:0];
      default: alu_result = '0;
    endcase
  end

  assign is_mul    = (op == OP_MUL);
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign ex_result = (state_q == MUL_BUSY) ? acc_step : alu_result;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state; flush overrides both start and completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!bus.flush_i && is_mul)                 state_d = MUL_BUSY;
      MUL_BUSY: if (bus.flush_i || cnt_q == 5'd31)          state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM: outputs; the final iteration cycle lets upstream advance
  always_comb begin
    stall = 1'b0;
    if (!bus.flush_i) begin
      case (state_q)
        IDLE:     stall = is_mul;
        MUL_BUSY: stall = (cnt_q != 5'd31);
        default:  stall = 1'b0;
      endcase
    end
  end

  assign bus.stall_o = stall & rst_n_i;

  // Multiplier datapath: one shift-add step per MUL_BUSY cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (bus.flush_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      if (is_mul) begin
        mcand_q  <= bus.RSdata_i;
        mplier_q <= bus.RTdata_i;
        acc_q    <= '0;
      end
    end else begin
      cnt_q    <= cnt_q + 5'd1;
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // EX/MEM register: bubble on flush or stall, otherwise the finished result
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.inst_o       <= '0;
      bus.ALUresult_o  <= '0;
      bus.store_data_o <= '0;
      bus.zero_o       <= 1'b0;
      bus.MEM_signal_o <= '0;
      bus.WB_signal_o  <= '0;
    end else if (bus.flush_i || stall) begin
      bus.inst_o       <= NOP_INST;
      bus.ALUresult_o  <= '0;
      bus.store_data_o <= '0;
      bus.zero_o       <= 1'b0;
      bus.MEM_signal_o <= '0;
      bus.WB_signal_o  <= '0;
    end else begin
      bus.inst_o       <= bus.inst_i;
      bus.ALUresult_o  <= ex_result;
      bus.store_data_o <= bus.store_data_i;
      bus.zero_o       <= (ex_result == 32'd0);
      bus.MEM_signal_o <= bus.MEM_signal_i;
      bus.WB_signal_o  <= bus.WB_signal_i;
    end
  end

endmodule
